// File: rtl/data_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped data cache controller: address field
// widths, line geometry and the controller state encoding.
package data_cache_ctrl_pkg;

   localparam int unsigned AddrW        = 16;
   localparam int unsigned WordW        = 16;
   localparam int unsigned WordsPerLine = 4;
   localparam int unsigned OffsetW      = 2;
   localparam int unsigned LineW        = WordsPerLine * WordW;  // 64
   localparam int unsigned LineAddrW    = AddrW - OffsetW;       // 14

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWrback = 2'd1,
      StFill   = 2'd2
   } cache_state_e;

   // Index width for a cache of 'lines' direct-mapped lines.
   function automatic int unsigned index_width(input int unsigned lines);
      return $clog2(lines);
   endfunction

   // Tag width: whatever address bits remain above index and offset.
   function automatic int unsigned tag_width(input int unsigned lines);
      return AddrW - OffsetW - $clog2(lines);
   endfunction

endpackage

// File: rtl/cache_array.sv
// Tag, valid, dirty and data storage for the direct-mapped cache. One read port
// and one write port that either loads a whole line (fill) or a single word (store).
module cache_array
   import data_cache_ctrl_pkg::*;
#(
   parameter int unsigned LINES = 8,
   parameter int unsigned IdxW  = 3,
   parameter int unsigned TagW  = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IdxW-1:0]    idx_i,
   input  logic               line_we_i,
   input  logic [TagW-1:0]    line_tag_i,
   input  logic [LineW-1:0]   line_data_i,
   input  logic               word_we_i,
   input  logic [OffsetW-1:0] word_off_i,
   input  logic [WordW-1:0]   word_data_i,
   output logic               valid_o,
   output logic               dirty_o,
   output logic [TagW-1:0]    tag_o,
   output logic [LineW-1:0]   line_o
);

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TagW-1:0]  tag_q  [LINES];
   logic [LineW-1:0] data_q [LINES];

   // Status bits: cleared by reset, set by a fill, dirtied by a store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (word_we_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; valid_q guards their contents.
   always_ff @(posedge clk) begin
      if (line_we_i) begin
         tag_q[idx_i]  <= line_tag_i;
         data_q[idx_i] <= line_data_i;
      end else if (word_we_i) begin
         data_q[idx_i][{word_off_i, 4'h0} +: WordW] <= word_data_i;
      end
   end

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign line_o  = data_q[idx_i];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM
// stage. Hits complete in the request cycle; misses stall the pipeline while the
// victim is written back (if dirty) and the line is refilled, then the frozen
// request replays and hits.
module data_cache_ctrl
   import data_cache_ctrl_pkg::*;
#(
   parameter int unsigned LINES              = 8,
   parameter int unsigned MEM_WORDS_PER_LINE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AddrW-1:0]     addr,
   input  logic [WordW-1:0]     wrData,
   input  logic                 memRd,
   input  logic                 memWr,
   output logic [WordW-1:0]     rdData,
   output logic                 stall,
   output logic [LineAddrW-1:0] m_addr,
   output logic [LineW-1:0]     m_wrData,
   output logic                 m_re,
   output logic                 m_we,
   input  logic [LineW-1:0]     m_rdData,
   input  logic                 m_rdy
);

   localparam int unsigned IdxW = index_width(LINES);
   localparam int unsigned TagW = tag_width(LINES);

   if (MEM_WORDS_PER_LINE != WordsPerLine) begin : g_bad_line_size
      $error("data_cache_ctrl supports only 4 words per line");
   end

   logic [OffsetW-1:0] offset;
   logic [IdxW-1:0]    index;
   logic [TagW-1:0]    tag;

   assign offset = addr[OffsetW-1:0];
   assign index  = addr[OffsetW +: IdxW];
   assign tag    = addr[AddrW-1 -: TagW];

   logic             arr_valid;
   logic             arr_dirty;
   logic [TagW-1:0]  arr_tag;
   logic [LineW-1:0] arr_line;

   cache_state_e         state_q;
   logic                 m_re_q;
   logic                 m_we_q;
   logic [LineAddrW-1:0] m_addr_q;
   logic [LineW-1:0]     m_wrdata_q;

   logic             req;
   logic             hit;
   logic [WordW-1:0] hit_word;
   logic             line_we;
   logic             word_we;

   // Hit detection and the word selected by the offset.
   always_comb begin
      req      = memRd | memWr;
      hit      = req & arr_valid & (arr_tag == tag);
      hit_word = arr_line[{offset, 4'h0} +: WordW];
   end

   // Array write enables: a fill completes on m_rdy, a store writes on a hit in idle.
   always_comb begin
      line_we = (state_q == StFill) & m_rdy;
      word_we = (state_q == StIdle) & memWr & hit;
   end

   // Pipeline-facing outputs; rst_n gating keeps stall low while reset is held.
   always_comb begin
      stall  = 1'b0;
      rdData = '0;
      if (rst_n) begin
         if (state_q == StIdle) begin
            stall = req & ~hit;
            if (memRd && hit) begin
               rdData = hit_word;
            end
         end else begin
            stall = 1'b1;
         end
      end
   end

   // Miss-handling FSM with registered memory-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         m_re_q     <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wrdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // m_rdy arriving here belongs to no transfer and is ignored.
               if (req && !hit) begin
                  if (arr_valid && arr_dirty) begin
                     state_q    <= StWrback;
                     m_we_q     <= 1'b1;
                     m_addr_q   <= {arr_tag, index};
                     m_wrdata_q <= arr_line;
                  end else begin
                     state_q  <= StFill;
                     m_re_q   <= 1'b1;
                     m_addr_q <= addr[AddrW-1:OffsetW];
                  end
               end
            end
            StWrback: begin
               if (m_rdy) begin
                  state_q    <= StFill;
                  m_we_q     <= 1'b0;
                  m_re_q     <= 1'b1;
                  m_addr_q   <= addr[AddrW-1:OffsetW];
                  m_wrdata_q <= '0;
               end
            end
            StFill: begin
               if (m_rdy) begin
                  state_q  <= StIdle;
                  m_re_q   <= 1'b0;
                  m_addr_q <= '0;
               end
            end
            default: begin
               state_q <= StIdle;
               m_re_q  <= 1'b0;
               m_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_re     = m_re_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wrData = m_wrdata_q;

   cache_array #(
      .LINES (LINES),
      .IdxW  (IdxW),
      .TagW  (TagW)
   ) u_cache_array (
      .clk         (clk),
      .rst_n       (rst_n),
      .idx_i       (index),
      .line_we_i   (line_we),
      .line_tag_i  (tag),
      .line_data_i (m_rdData),
      .word_we_i   (word_we),
      .word_off_i  (offset),
      .word_data_i (wrData),
      .valid_o     (arr_valid),
      .dirty_o     (arr_dirty),
      .tag_o       (arr_tag),
      .line_o      (arr_line)
   );

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: directed scenarios, then randomized traffic checked
// by a scoreboard against a flat word-memory model and a line-residency model.
module tb_data_cache_ctrl;

   localparam int unsigned LINES = 8;
   localparam int unsigned IdxW  = $clog2(LINES);

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic [15:0] wrData;
   logic        memRd;
   logic        memWr;
   logic [15:0] rdData;
   logic        stall;
   logic [13:0] m_addr;
   logic [63:0] m_wrData;
   logic        m_re;
   logic        m_we;
   logic [63:0] m_rdData;
   logic        m_rdy;

   int checks = 0;
   int errors = 0;

   bit mon_en   = 1'b0;
   bit mem_auto = 1'b0;

   typedef struct {
      bit          rd;
      logic [15:0] data;
      bit          hit;
      logic [15:0] a;
   } exp_t;

   exp_t             sb[$];
   logic [15:0]      ref_mem[int];  // architectural memory seen by the pipeline
   logic [63:0]      back[int];     // main memory behind the cache
   int               res_tag[LINES];

   always #5 clk = ~clk;

   data_cache_ctrl #(
      .LINES              (LINES),
      .MEM_WORDS_PER_LINE (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .wrData   (wrData),
      .memRd    (memRd),
      .memWr    (memWr),
      .rdData   (rdData),
      .stall    (stall),
      .m_addr   (m_addr),
      .m_wrData (m_wrData),
      .m_re     (m_re),
      .m_we     (m_we),
      .m_rdData (m_rdData),
      .m_rdy    (m_rdy)
   );

   function automatic logic [15:0] init_word(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] ref_word(input logic [15:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_word(a);
   endfunction

   function automatic logic [63:0] back_line(input logic [13:0] la);
      if (back.exists(int'(la))) return back[int'(la)];
      return {init_word({la, 2'd3}), init_word({la, 2'd2}),
              init_word({la, 2'd1}), init_word({la, 2'd0})};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   // Main-memory responder: random latency, one-cycle m_rdy pulse.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mem_auto && rst_n && (m_re || m_we)) begin
            int lat;
            lat = $urandom_range(0, 3);
            repeat (lat) @(posedge clk);
            #1;
            if (m_we) begin
               back[int'(m_addr)] = m_wrData;
            end else begin
               m_rdData = back_line(m_addr);
            end
            m_rdy = 1'b1;
            @(posedge clk);
            #1;
            m_rdy = 1'b0;
         end
      end
   end

   // Scoreboard monitor: each cycle a request is presented without stall, one
   // expected response is retired.
   initial begin
      int stall_cnt;
      exp_t e;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            checks++;
            if (m_re && m_we) begin
               errors++;
               $display("FAIL mem_exclusive: m_re=%0d m_we=%0d, expected not both", m_re, m_we);
            end
            if (memRd || memWr) begin
               if (stall) begin
                  stall_cnt++;
               end else if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_empty: response at addr %h, expected none", addr);
               end else begin
                  e = sb.pop_front();
                  if (e.rd) begin
                     checks++;
                     if (rdData !== e.data) begin
                        errors++;
                        $display("FAIL load_data addr %h: got %h, expected %h", e.a, rdData, e.data);
                     end
                  end
                  checks++;
                  if ((stall_cnt == 0) != e.hit) begin
                     errors++;
                     $display("FAIL hit_latency addr %h: stall cycles %0d, expected hit=%0d",
                              e.a, stall_cnt, e.hit);
                  end
                  stall_cnt = 0;
               end
            end
         end else begin
            stall_cnt = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      addr     = 16'h0040;
      wrData   = 16'h0000;
      memRd    = 1'b1;
      memWr    = 1'b0;
      m_rdData = '0;
      m_rdy    = 1'b0;
      #2;
      // Reset values, with a request already pending.
      chk("rst_stall", stall, 0);
      chk("rst_m_re", m_re, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_rdData", rdData, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wrData", m_wrData, 0);

      // Test 1: cold load miss and fill.
      drive_edge();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_miss_stall", stall, 1);
      chk("t1_miss_m_re", m_re, 0);
      @(negedge clk);
      chk("t1_fill_m_re", m_re, 1);
      chk("t1_fill_m_we", m_we, 0);
      chk("t1_fill_m_addr", m_addr, 14'h0010);
      drive_edge();
      m_rdData = 64'h0004_0003_0002_0001;
      m_rdy    = 1'b1;
      @(negedge clk);
      chk("t1_rdy_stall", stall, 1);
      drive_edge();
      m_rdy = 1'b0;
      @(negedge clk);
      chk("t1_done_stall", stall, 0);
      chk("t1_done_rdData", rdData, 16'h0001);
      chk("t1_done_m_re", m_re, 0);

      // Test 2: store hit then load hit.
      drive_edge();
      memRd  = 1'b0;
      memWr  = 1'b1;
      addr   = 16'h0041;
      wrData = 16'hBEEF;
      @(negedge clk);
      chk("t2_store_stall", stall, 0);
      drive_edge();
      memWr = 1'b0;
      memRd = 1'b1;
      @(negedge clk);
      chk("t2_load_stall", stall, 0);
      chk("t2_load_rdData", rdData, 16'hBEEF);

      // Test 3: conflict miss on a dirty line -> writeback then fill.
      drive_edge();
      addr = 16'h0060;
      @(negedge clk);
      chk("t3_miss_stall", stall, 1);
      chk("t3_miss_m_we", m_we, 0);
      @(negedge clk);
      chk("t3_wb_m_we", m_we, 1);
      chk("t3_wb_m_re", m_re, 0);
      chk("t3_wb_m_addr", m_addr, 14'h0010);
      chk("t3_wb_m_wrData", m_wrData, 64'h0004_0003_BEEF_0001);
      drive_edge();
      m_rdy = 1'b1;
      @(negedge clk);
      chk("t3_wb_rdy_stall", stall, 1);
      drive_edge();
      m_rdy = 1'b0;
      @(negedge clk);
      chk("t3_fill_m_re", m_re, 1);
      chk("t3_fill_m_we", m_we, 0);
      chk("t3_fill_m_addr", m_addr, 14'h0018);
      chk("t3_fill_stall", stall, 1);

      // Test 4: reset in the middle of the fill.
      #1;
      rst_n = 1'b0;
      #1;
      chk("t4_rst_m_re", m_re, 0);
      chk("t4_rst_stall", stall, 0);
      chk("t4_rst_m_addr", m_addr, 0);
      drive_edge();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4_remiss_stall", stall, 1);
      @(negedge clk);
      chk("t4_refill_m_re", m_re, 1);
      chk("t4_refill_m_addr", m_addr, 14'h0018);
      drive_edge();
      m_rdData = 64'h0008_0007_0006_0005;
      m_rdy    = 1'b1;
      drive_edge();
      m_rdy = 1'b0;
      @(negedge clk);
      chk("t4_done_stall", stall, 0);
      chk("t4_done_rdData", rdData, 16'h0005);

      // Test 5: load and store together on a hit.
      drive_edge();
      addr   = 16'h0061;
      memWr  = 1'b1;
      wrData = 16'h1234;
      @(negedge clk);
      chk("t5_both_stall", stall, 0);
      chk("t5_both_rdData", rdData, 16'h0006);
      drive_edge();
      memWr = 1'b0;
      @(negedge clk);
      chk("t5_load_rdData", rdData, 16'h1234);

      // Test 6: stray m_rdy in idle.
      drive_edge();
      memRd = 1'b0;
      m_rdy = 1'b1;
      @(negedge clk);
      chk("t6_m_re", m_re, 0);
      chk("t6_m_we", m_we, 0);
      chk("t6_stall", stall, 0);
      chk("t6_rdData", rdData, 0);
      drive_edge();
      m_rdy = 1'b0;
      @(negedge clk);
      chk("t6_after_m_re", m_re, 0);
      chk("t6_after_m_we", m_we, 0);
      drive_edge();
      memRd = 1'b1;
      @(negedge clk);
      chk("t6_hit_stall", stall, 0);
      chk("t6_hit_rdData", rdData, 16'h1234);

      // Randomized phase from a clean reset.
      drive_edge();
      memRd = 1'b0;
      rst_n = 1'b0;
      ref_mem.delete();
      back.delete();
      foreach (res_tag[i]) res_tag[i] = -1;
      drive_edge();
      rst_n    = 1'b1;
      mon_en   = 1'b1;
      mem_auto = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            memRd = 1'b0;
            memWr = 1'b0;
            addr  = 16'($urandom);
            @(negedge clk);
            chk("idle_stall", stall, 0);
            chk("idle_rdData", rdData, 0);
            drive_edge();
         end else begin
            exp_t        e;
            logic [15:0] a;
            logic [15:0] wd;
            int          op;
            int          idx;
            int          tg;
            int          cyc;
            a   = 16'($urandom_range(0, 255));
            wd  = 16'($urandom);
            op  = $urandom_range(0, 9);
            idx = (int'(a) >> 2) % LINES;
            tg  = int'(a) >> (2 + IdxW);
            e.a    = a;
            e.rd   = (op < 5) || (op == 9);
            e.data = ref_word(a);
            e.hit  = (res_tag[idx] == tg);
            res_tag[idx] = tg;
            if (op >= 5) ref_mem[int'(a)] = wd;
            sb.push_back(e);
            addr   = a;
            wrData = wd;
            memRd  = e.rd;
            memWr  = (op >= 5);
            cyc    = 0;
            do begin
               @(negedge clk);
               cyc++;
            end while (stall && cyc < 100);
            if (stall) begin
               checks++;
               errors++;
               $display("FAIL req_timeout addr %h: stall still 1 after %0d cycles, expected 0",
                        a, cyc);
               sb.delete();
            end
            drive_edge();
         end
      end
      memRd = 1'b0;
      memWr = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter LINES, default 8, number of direct-mapped lines (power of 2, 2..64).
REQ-002 Parameter MEM_WORDS_PER_LINE, fixed 4, words per line; no other value is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 addr  input  16  word address from the MEM stage (aluResult).
REQ-006 wrData  input  16  store data from the MEM stage.
REQ-007 memRd  input  1  load request.
REQ-008 memWr  input  1  store request.
REQ-009 rdData  output  16  load data, combinational on hit.
REQ-010 stall  output  1  high while a request cannot complete this cycle; drives the pipeline enables low.
REQ-011 m_addr  output  14  line address to main memory.
REQ-012 m_wrData  output  64  victim line; word 0 at bits [15:0].
REQ-013 m_re  output  1  line read request.
REQ-014 m_we  output  1  line write request.
REQ-015 m_rdData  input  64  fill line; same word order as m_wrData.
REQ-016 m_rdy  input  1  one-cycle pulse: current m_re/m_we transfer is complete.

Function
REQ-017 Address split: offset = addr[1:0], index = addr[1+log2(LINES):2], tag = remaining upper bits.
REQ-018 Each line SHALL hold a valid bit, a dirty bit, a tag and 4x16-bit data.
REQ-019 Hit = memRd or memWr, valid[index] set, and tag match.
REQ-020 Load hit: rdData = selected word in the same cycle; stall = 0.
REQ-021 Store hit: word written and dirty set on the next rising edge; stall = 0.
REQ-022 memRd and memWr both high: treated as a store; rdData still shows the old word.
REQ-023 No request: stall = 0, no state change; rdData = 16'h0000.
REQ-024 States: IDLE, WRBACK, FILL.
REQ-025 IDLE, miss, victim dirty -> WRBACK; IDLE, miss, victim clean or invalid -> FILL; stall = 1 combinationally in the miss cycle.
REQ-026 WRBACK: m_we = 1, m_addr = {victim tag, index}, m_wrData = victim data; on m_rdy -> FILL.
REQ-027 FILL: m_re = 1, m_addr = addr[15:2]; on m_rdy the line is loaded from m_rdData, tag is written, valid = 1, dirty = 0, next state IDLE.
REQ-028 stall SHALL remain 1 throughout WRBACK and FILL, including the m_rdy cycle.
REQ-029 After FILL, the replayed request in IDLE hits: a store then sets dirty and merges wrData.
REQ-030 Request inputs are held stable by the frozen pipeline while stall = 1; the block does not latch them.
REQ-031 m_re and m_we are never high together; both are 0 in IDLE.
REQ-032 m_rdy seen in IDLE is ignored.
REQ-033 Miss-to-ready latency: clean miss = memory latency + 1 cycle; dirty miss = 2 memory latencies + 1 cycle.

Reset
REQ-034 rst_n low SHALL asynchronously set state to IDLE and clear all valid and dirty bits.
REQ-035 During reset, stall, m_re, m_we and rdData are 0, and m_addr and m_wrData are 0.
REQ-036 Data and tag arrays are not reset.
REQ-037 Reset during WRBACK or FILL abandons the transfer; the line is left invalid and no partial fill is written.

Structure
REQ-038 A shared package holds the state encoding, the tag, index and offset widths derived from LINES, and the line width (64).
REQ-039 Sub-module cache_array holds the tag, valid, dirty and data storage with one read port and one line- or word-write port; the FSM and hit logic live in data_cache_ctrl.

Verification
REQ-040 Test 1: after reset, load addr 16'h0040 -> stall = 1, FILL with m_addr 14'h0010; memory returns 64'h0004_0003_0002_0001 -> stall drops and rdData = 16'h0001.
REQ-041 Test 2: store 16'hBEEF to 16'h0041 (hit), then load 16'h0041 -> zero stall, rdData = 16'hBEEF, dirty[0] = 1.
REQ-042 Test 3: with LINES = 8, load 16'h0060 (same index, new tag) -> WRBACK with m_addr 14'h0010 and m_wrData holding 16'hBEEF in bits [31:16], then FILL with m_addr 14'h0018.
REQ-043 Test 4: assert rst_n low in the middle of FILL -> m_re = 0 immediately; the next load to the same address misses again.
REQ-044 Test 5: memRd and memWr both high on a hit, wrData 16'h1234 -> rdData shows the old word; the next-cycle load returns 16'h1234.
REQ-045 Test 6: pulse m_rdy in IDLE with no request -> no state change, and m_re and m_we stay 0.
